// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and a req/ack memory.
// Define SB_FORWARD_EN to forward load hits from the buffer; otherwise loads drain it first.
module dmem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WR,
  input  logic                     RD,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [DATA_W-1:0]        WRData,
  output logic [DATA_W-1:0]        RDData,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_full,
  output logic                     sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD,
    LDONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] ld_data_q;

  logic              full, empty;
  logic              rd_req, enq, pop;
  logic              ld_hit, ld_miss;
  logic [DATA_W-1:0] fwd_data;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_req  = RD & ~WR;
  assign enq     = WR & ~full;
  assign pop     = (state_q == DRAIN) & mem_ack;
  assign count_d = count_q + CW'(enq) - CW'(pop);

`ifdef SB_FORWARD_EN
  logic          fwd_hit;
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[fwd_idx] == Address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign ld_hit  = rd_req & fwd_hit;
  assign ld_miss = rd_req & ~fwd_hit;
`else
  assign fwd_data = '0;
  assign ld_hit   = 1'b0;
  assign ld_miss  = rd_req & empty;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ld_miss) begin
          state_d = LOAD;
        end else if (!empty) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d = ld_miss ? LOAD : IDLE;
        end
      end
      LOAD: begin
        if (mem_ack) begin
          state_d = LDONE;
        end
      end
      LDONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == DRAIN) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = addr_q[head_q];
      mem_wdata = data_q[head_q];
    end else if (state_q == LOAD) begin
      mem_req   = 1'b1;
      mem_addr  = Address;
    end
  end

  // Held in reset the core must not be frozen.
  assign stall = rst & ((WR & full) |
                 (rd_req & (state_q != LDONE) & ~ld_hit));

  assign RDData   = ld_hit ? fwd_data : ld_data_q;
  assign sb_count = count_q;
  assign sb_full  = full;
  assign sb_empty = empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ld_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (enq) begin
        addr_q[tail_q] <= Address;
        data_q[tail_q] <= WRData;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      if ((state_q == LOAD) && mem_ack) begin
        ld_data_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: memory responder,
// architectural memory model and per-scenario tasks.
module tb_dmem_store_buffer;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          WR, RD;
  logic [AW-1:0] Address;
  logic [DW-1:0] WRData, RDData;
  logic          stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] sb_count;
  logic          sb_full, sb_empty;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          txn_log[$];
  txn_t          exp_wr[$];
  logic [DW-1:0] dmem    [512];
  logic [DW-1:0] ref_mem [512];

  int vectors     = 0;
  int miscompares = 0;
  int ack_wait    = 0;
  int ack_budget  = -1;
  bit spur_en     = 0;
  int stab_viol   = 0;
  int rcnt        = 0;

  logic          m_req = 0;
  logic          m_ack = 0;
  logic [41:0]   m_bus = '0;

  dmem_store_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .WR        (WR),
    .RD        (RD),
    .Address   (Address),
    .WRData    (WRData),
    .RDData    (RDData),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .sb_count  (sb_count),
    .sb_full   (sb_full),
    .sb_empty  (sb_empty)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Memory responder: acks after ack_wait request cycles, limited by ack_budget.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst) begin
        rcnt = 0;
      end else if (mem_req) begin
        if (ack_budget != 0 && rcnt >= ack_wait) begin
          mem_ack = 1'b1;
          rcnt    = 0;
          if (ack_budget > 0) ack_budget--;
          if (mem_we) begin
            dmem[mem_addr] = mem_wdata;
            txn_log.push_back('{1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = dmem[mem_addr];
            txn_log.push_back('{1'b0, mem_addr, dmem[mem_addr]});
          end
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Bus stability while a request is open and not yet acknowledged.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && m_req && !m_ack && mem_req &&
          ({mem_we, mem_addr, mem_wdata} !== m_bus))
        stab_viol++;
      m_req = rst && mem_req;
      m_ack = mem_ack;
      m_bus = {mem_we, mem_addr, mem_wdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    txn_log.delete();
    exp_wr.delete();
  endtask

  task automatic core_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit with_rd, output int sc);
    sc      = 0;
    WR      = 1'b1;
    RD      = with_rd;
    Address = a;
    WRData  = d;
    forever begin
      @(negedge clk);
      if (!stall) break;
      sc++;
      if (sc > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL store_timeout stall=%b required 0", stall);
        break;
      end
    end
    ref_mem[a] = d;
    exp_wr.push_back('{1'b1, a, d});
    tick();
    WR = 1'b0;
    RD = 1'b0;
  endtask

  task automatic core_load(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output int sc);
    sc      = 0;
    WR      = 1'b0;
    RD      = 1'b1;
    Address = a;
    forever begin
      @(negedge clk);
      if (!stall) break;
      sc++;
      if (sc > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL load_timeout stall=%b required 0", stall);
        break;
      end
    end
    d = RDData;
    tick();
    RD = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    forever begin
      @(negedge clk);
      if (sb_empty && !mem_req) break;
      n++;
      if (n > 300) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout sb_count=%0d required 0", sb_count);
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    WR      = 1'b0;
    RD      = 1'b0;
    Address = '0;
    WRData  = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 43'h0) begin
      miscompares++;
      $display("FAIL rst_mem got=%h required 0",
               {mem_req, mem_we, mem_addr, mem_wdata});
    end
    vectors++;
    if (RDData !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_rddata got=%h required 0", RDData);
    end
    vectors++;
    if (sb_count !== 3'd0 || sb_full !== 1'b0 || sb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_flags got=%0d/%b/%b required 0/0/1",
               sb_count, sb_full, sb_empty);
    end
    RD      = 1'b1;
    Address = 9'h033;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall got=%b required 0", stall);
    end
    RD = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_store();
    int sc;
    clear_logs();
    ack_wait   = 1;
    ack_budget = -1;
    core_store(9'h010, 32'hDEADBEEF, 1'b0, sc);
    vectors++;
    if (sc !== 0) begin
      miscompares++;
      $display("FAIL single_stall got=%0d required 0", sc);
    end
    vectors++;
    if (sb_count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_count1 got=%0d required 1", sb_count);
    end
    wait_drained();
    vectors++;
    if (sb_count !== 3'd0) begin
      miscompares++;
      $display("FAIL single_count0 got=%0d required 0", sb_count);
    end
    vectors++;
    if (txn_log.size() != 1 || txn_log[0] !== txn_t'({1'b1, 9'h010, 32'hDEADBEEF})) begin
      miscompares++;
      $display("FAIL single_write got=%0d txns required 1 write 010/deadbeef",
               txn_log.size());
    end
  endtask

  task automatic test_fill_full();
    int sc, sc5;
    clear_logs();
    ack_wait   = 0;
    ack_budget = 0;
    for (int i = 0; i < 4; i++) begin
      core_store(9'($urandom_range(0, 511)), $urandom, 1'b0, sc);
      vectors++;
      if (sc !== 0) begin
        miscompares++;
        $display("FAIL fill_stall%0d got=%0d required 0", i, sc);
      end
    end
    vectors++;
    if (sb_full !== 1'b1 || sb_count !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_full got=%b/%0d required 1/4", sb_full, sb_count);
    end
    fork
      core_store(9'h1F0, 32'h5555AAAA, 1'b0, sc5);
      begin
        repeat (3) @(posedge clk);
        ack_budget = -1;
      end
    join
    vectors++;
    if (sc5 !== 4) begin
      miscompares++;
      $display("FAIL full_stall_cycles got=%0d required 4", sc5);
    end
    wait_drained();
    vectors++;
    if (txn_log.size() != exp_wr.size()) begin
      miscompares++;
      $display("FAIL fill_order_len got=%0d required %0d",
               txn_log.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        vectors++;
        if (txn_log[i] !== exp_wr[i]) begin
          miscompares++;
          $display("FAIL fill_order%0d got=%h required %h",
                   i, txn_log[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_forward();
    int sc;
    logic [DW-1:0] d;
    txn_t exp[$];
    clear_logs();
    ack_wait   = 0;
    ack_budget = 0;
    core_store(9'h020, 32'h11, 1'b0, sc);
    core_store(9'h020, 32'h22, 1'b0, sc);
    exp.push_back('{1'b1, 9'h020, 32'h11});
    exp.push_back('{1'b1, 9'h020, 32'h22});
`ifdef SB_FORWARD_EN
    core_load(9'h020, d, sc);
    vectors++;
    if (sc !== 0) begin
      miscompares++;
      $display("FAIL fwd_stall got=%0d required 0", sc);
    end
    ack_budget = -1;
    wait_drained();
`else
    fork
      core_load(9'h020, d, sc);
      begin
        repeat (2) @(posedge clk);
        ack_budget = -1;
      end
    join
    exp.push_back('{1'b0, 9'h020, 32'h22});
`endif
    vectors++;
    if (d !== ref_mem[9'h020]) begin
      miscompares++;
      $display("FAIL fwd_data got=%h required %h", d, ref_mem[9'h020]);
    end
    vectors++;
    if (txn_log.size() != exp.size()) begin
      miscompares++;
      $display("FAIL fwd_txn_len got=%0d required %0d",
               txn_log.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        vectors++;
        if (txn_log[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL fwd_txn%0d got=%h required %h", i, txn_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_load_miss();
    int sc;
    logic [DW-1:0] d;
    clear_logs();
    ack_wait          = 0;
    ack_budget        = -1;
    dmem[9'h040]      = 32'hCAFEF00D;
    ref_mem[9'h040]   = 32'hCAFEF00D;
    core_load(9'h040, d, sc);
    vectors++;
    if (sc !== 2) begin
      miscompares++;
      $display("FAIL miss_stall got=%0d required 2", sc);
    end
    vectors++;
    if (d !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL miss_data got=%h required cafef00d", d);
    end
    vectors++;
    if (txn_log.size() != 1 || txn_log[0] !== txn_t'({1'b0, 9'h040, 32'hCAFEF00D})) begin
      miscompares++;
      $display("FAIL miss_txn got=%0d txns required 1 read @040", txn_log.size());
    end
  endtask

  task automatic test_miss_during_drain();
    int sc, n;
    logic [DW-1:0] d, wd;
    clear_logs();
    stab_viol  = 0;
    ack_wait   = 3;
    ack_budget = -1;
    wd = $urandom;
    core_store(9'h0A0, wd, 1'b0, sc);
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_req) break;
      n++;
      if (n > 20) begin
        vectors++;
        miscompares++;
        $display("FAIL mdd_req_timeout mem_req=%b required 1", mem_req);
        break;
      end
    end
    tick();
    core_load(9'h050, d, sc);
    vectors++;
    if (d !== ref_mem[9'h050]) begin
      miscompares++;
      $display("FAIL mdd_data got=%h required %h", d, ref_mem[9'h050]);
    end
    vectors++;
    if (txn_log.size() != 2 ||
        txn_log[0] !== txn_t'({1'b1, 9'h0A0, wd}) ||
        txn_log[1] !== txn_t'({1'b0, 9'h050, ref_mem[9'h050]})) begin
      miscompares++;
      $display("FAIL mdd_order got=%0d txns required write@0a0 then read@050",
               txn_log.size());
    end
    vectors++;
    if (stab_viol !== 0) begin
      miscompares++;
      $display("FAIL mdd_stable got=%0d changes required 0", stab_viol);
    end
  endtask

  task automatic test_reset_mid_load();
    int sc, n;
    logic [DW-1:0] d0;
    clear_logs();
    ack_wait   = 0;
    ack_budget = 0;
    d0 = $urandom;
    core_store(9'h0B0, d0, 1'b0, sc);
    core_store(9'h0B1, $urandom, 1'b0, sc);
    core_store(9'h0B2, $urandom, 1'b0, sc);
    RD         = 1'b1;
    Address    = 9'h0C0;
    ack_budget = 1;
    n = 0;
    forever begin
      @(negedge clk);
`ifdef SB_FORWARD_EN
      if (mem_req && !mem_we) break;
`else
      if (sb_count == 3'd2) break;
`endif
      n++;
      if (n > 30) begin
        vectors++;
        miscompares++;
        $display("FAIL rml_timeout sb_count=%0d mem_we=%b", sb_count, mem_we);
        break;
      end
    end
    vectors++;
    if (sb_count !== 3'd2) begin
      miscompares++;
      $display("FAIL rml_pre_count got=%0d required 2", sb_count);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rml_req_stall got=%b/%b required 0/0", mem_req, stall);
    end
    vectors++;
    if (sb_count !== 3'd0 || sb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rml_count got=%0d/%b required 0/1", sb_count, sb_empty);
    end
    RD = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    ack_budget = -1;
    repeat (10) tick();
    vectors++;
    if (txn_log.size() != 1 || txn_log[0] !== txn_t'({1'b1, 9'h0B0, d0})) begin
      miscompares++;
      $display("FAIL rml_discard got=%0d txns required only write@0b0",
               txn_log.size());
    end
    for (int i = 0; i < 512; i++) ref_mem[i] = dmem[i];
  endtask

  task automatic test_random();
    int sc, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    txn_t wr[$];
    clear_logs();
    stab_viol  = 0;
    ack_budget = -1;
    spur_en    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ack_wait = $urandom_range(0, 3);
      a = 9'h180 + 9'($urandom_range(0, 7) * 4);
      r = $urandom_range(0, 9);
      if (r < 5) begin
        core_store(a, $urandom, (r == 0), sc);
      end else if (r < 8) begin
        core_load(a, d, sc);
        vectors++;
        if (d !== ref_mem[a]) begin
          miscompares++;
          $display("FAIL rnd_load%0d @%h got=%h required %h", i, a, d, ref_mem[a]);
        end
      end else begin
        tick();
      end
    end
    spur_en = 1'b0;
    wait_drained();
    foreach (txn_log[i]) if (txn_log[i].we) wr.push_back(txn_log[i]);
    vectors++;
    if (wr.size() != exp_wr.size()) begin
      miscompares++;
      $display("FAIL rnd_wr_len got=%0d required %0d", wr.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        vectors++;
        if (wr[i] !== exp_wr[i]) begin
          miscompares++;
          $display("FAIL rnd_wr%0d got=%h required %h", i, wr[i], exp_wr[i]);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      a = 9'h180 + 9'(k * 4);
      vectors++;
      if (dmem[a] !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL rnd_mem @%h got=%h required %h", a, dmem[a], ref_mem[a]);
      end
    end
    vectors++;
    if (stab_viol !== 0) begin
      miscompares++;
      $display("FAIL rnd_stable got=%0d changes required 0", stab_viol);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 512; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    test_reset();
    test_single_store();
    test_fill_full();
    test_forward();
    test_load_miss();
    test_miss_during_drain();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write store buffer between the core's data-memory port (WR, RD, Address, WRData, RDData) and a single-ported, request/acknowledge data memory. Stores retire into a small FIFO without stalling the core; the FIFO drains to memory in the background. Loads are serviced by buffer forwarding or by a memory read. A stall output freezes the core while a load miss is outstanding or the buffer is full.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 9, address width, matches core Address
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- WR  in  1  core store request
- RD  in  1  core load request
- Address  in  ADDR_W  core byte address, passed unchanged to memory
- WRData  in  DATA_W  core store data
- RDData  out  DATA_W  load data to core
- stall  out  1  core must hold WR/RD/Address/WRData and not advance
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack on a read
- mem_ack  in  1  one-cycle completion pulse
- sb_count  out  $clog2(DEPTH)+1  buffer occupancy
- sb_full  out  1  sb_count == DEPTH
- sb_empty  out  1  sb_count == 0

## Operation
- Buffer: circular FIFO of {addr, data}; head/tail pointers wrap modulo DEPTH; count tracks occupancy.
- Store: WR=1 and count<DEPTH → enqueue at the clock edge, stall=0. WR=1 and full → stall=1 until count<DEPTH; a pop in the same cycle does not relieve a full stall.
- WR and RD both 1: store only; RD ignored.
- Load hit (forwarding enabled, RD=1, Address matches a valid entry): RDData = data of youngest matching entry, combinational, stall=0.
- Load miss: stall=1; a memory read is issued; RDData comes from the captured read data.
- FSM states: IDLE, DRAIN, LOAD, LDONE.
- IDLE → LOAD when RD miss; has priority over drain.
- IDLE → DRAIN when count>0 and no RD miss.
- DRAIN: mem_req=1, mem_we=1, head entry on mem_addr/mem_wdata. On mem_ack, pop head, then go to LOAD if RD miss is present, else IDLE.
- LOAD: mem_req=1, mem_we=0, mem_addr=Address. On mem_ack, capture mem_rdata into ld_data and go to LDONE.
- LDONE: stall=0, RDData=ld_data, then IDLE.
- Only one memory transaction is outstanding at a time. mem_addr, mem_wdata and mem_we stay stable while mem_req=1.

## Timing
- Store: zero stall cycles when not full; sb_count increments the cycle after the edge.
- Drain: mem_req rises at least one cycle after an entry is enqueued. Pop occurs on the ack edge.
- Load miss latency: 1 (IDLE→LOAD) + memory wait + 1 (LDONE). With mem_ack on the first request cycle, stall is high for 2 cycles.
- Load miss arriving during DRAIN waits for that drain's ack.
- Reset (rst=0, asynchronous, any state, including mid-transaction): FSM=IDLE, buffer emptied (pending stores discarded), pointers/count=0.
- Reset output values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, RDData=0, stall=0, sb_count=0, sb_full=0, sb_empty=1.
- A mem_ack arriving while mem_req=0 is ignored.

## Configuration
- SB_FORWARD_EN defined: load hits forward from the buffer as described above.
- SB_FORWARD_EN undefined: a load with sb_empty=0 stalls while the buffer fully drains, then proceeds as a miss. A load with sb_empty=1 proceeds as a miss immediately.

## Test plan
- Reset, then store 0xDEADBEEF @0x010 with mem_ack after 1 wait cycle → stall never 1; mem write with addr 0x010, data 0xDEADBEEF; sb_count 1→0.
- Four stores with mem_ack held 0 → sb_full=1; fifth store stalls until an ack; memory writes appear in FIFO order.
- Stores 0x11 then 0x22 @0x020 (no acks), load @0x020 with forwarding enabled → RDData=0x22 same cycle, stall=0. With forwarding disabled → both writes drain first, then a read is issued.
- Load miss @0x040 with mem_rdata=0xCAFEF00D and immediate ack → stall high exactly 2 cycles; RDData=0xCAFEF00D in LDONE.
- Load miss arrives during a drain in flight → drain completes, then the read issues; mem_we never changes while mem_req=1.
- rst=0 during LOAD with 2 entries buffered → mem_req drops immediately, sb_count=0, stall=0; buffered stores are never written.
